// File: rtl/coin_insert_ctrl.sv
// rtl/coin_insert_ctrl.sv - coin insertion session controller with credits and insert timeout
module coin_insert_ctrl #(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int CREDIT_W     = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_valid_i,
    input  logic [3:0]          coin_num_per_round_i,
    input  logic [3:0]          coins_to_insert_i,
    input  logic [3:0]          wait_time_for_insert_i,
    input  logic                coin_in_i,
    input  logic                round_done_i,
    output logic [CREDIT_W-1:0] credits_o,
    output logic [3:0]          coins_inserted_o,
    output logic [3:0]          time_left_o,
    output logic                insert_active_o,
    output logic                game_start_o,
    output logic                timeout_o
);

    localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_COIN = 2'd1,
        READY     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          npr_q, npr_d;
    logic [3:0]          ncoin_q, ncoin_d;
    logic [3:0]          twait_q, twait_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [3:0]          coins_q, coins_d;
    logic [3:0]          time_left_q, time_left_d;
    logic                game_start_q, game_start_d;
    logic                timeout_q, timeout_d;
    logic                credit_inc;
    logic                credit_dec;
    logic                tick;

    // State and datapath registers; reset clears everything asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            npr_q        <= 4'd0;
            ncoin_q      <= 4'd0;
            twait_q      <= 4'd0;
            presc_q      <= '0;
            cnt_q        <= 4'd0;
            credits_q    <= '0;
            coins_q      <= 4'd0;
            time_left_q  <= 4'd0;
            game_start_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            npr_q        <= npr_d;
            ncoin_q      <= ncoin_d;
            twait_q      <= twait_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            credits_q    <= credits_d;
            coins_q      <= coins_d;
            time_left_q  <= time_left_d;
            game_start_q <= game_start_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic: cfg_valid restarts from any state, otherwise per-state session handling
    always_comb begin
        state_d      = state_q;
        npr_d        = npr_q;
        ncoin_d      = ncoin_q;
        twait_d      = twait_q;
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        coins_d      = coins_q;
        time_left_d  = time_left_q;
        game_start_d = 1'b0;
        timeout_d    = 1'b0;
        credit_inc   = 1'b0;
        tick         = 1'b0;

        if (cfg_valid_i) begin
            npr_d       = (coin_num_per_round_i == 4'd0) ? 4'd1 : coin_num_per_round_i;
            ncoin_d     = coins_to_insert_i;
            twait_d     = wait_time_for_insert_i;
            coins_d     = 4'd0;
            cnt_d       = 4'd0;
            time_left_d = wait_time_for_insert_i;
            presc_d     = PRESC_MAX;
            if (coins_to_insert_i == 4'd0) begin
                state_d      = READY;
                game_start_d = 1'b1;
            end else begin
                state_d = WAIT_COIN;
            end
        end else begin
            case (state_q)
                WAIT_COIN: begin
                    tick = (presc_q == '0);
                    if (tick) begin
                        presc_d = PRESC_MAX;
                        if (time_left_q != 4'd0) begin
                            time_left_d = time_left_q - 4'd1;
                        end
                    end else begin
                        presc_d = presc_q - PW'(1);
                    end
                    // A coin beats an expiry tick in the same cycle
                    if (coin_in_i) begin
                        coins_d = coins_q + 4'd1;
                        if (cnt_q + 4'd1 == npr_q) begin
                            cnt_d      = 4'd0;
                            credit_inc = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                        time_left_d = twait_q;
                        presc_d     = PRESC_MAX;
                        if (coins_q + 4'd1 == ncoin_q) begin
                            game_start_d = 1'b1;
                            state_d      = READY;
                        end
                    end else if (tick && twait_q != 4'd0 && time_left_q == 4'd1) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                READY: begin
                    if (round_done_i && credits_q == CREDIT_W'(1)) begin
                        coins_d     = 4'd0;
                        cnt_d       = 4'd0;
                        time_left_d = twait_q;
                        presc_d     = PRESC_MAX;
                        state_d     = WAIT_COIN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Credit counter: a coin credit and a consumed round in one cycle cancel out
    always_comb begin
        credit_dec = round_done_i && (credits_q != '0);
        credits_d  = credits_q;
        if (credit_inc && !credit_dec) begin
            if (credits_q != CREDIT_MAX) begin
                credits_d = credits_q + CREDIT_W'(1);
            end
        end else if (credit_dec && !credit_inc) begin
            credits_d = credits_q - CREDIT_W'(1);
        end
    end

    assign credits_o        = credits_q;
    assign coins_inserted_o = coins_q;
    assign time_left_o      = time_left_q;
    assign insert_active_o  = (state_q == WAIT_COIN);
    assign game_start_o     = game_start_q;
    assign timeout_o        = timeout_q;

endmodule
